fixed_divider: RTL

- Iterative signed fixed-point divider producing quotient = num / den in Q16.16.
- Sits directly upstream of the natural-log stage in the pricing pipeline: it forms the spot/strike ratio S/K. Its `out`/`valid` feed the log stage's `in`/`start`.
- Radix-2 restoring division, one quotient bit per cycle, with explicit divide-by-zero and overflow saturation.

---
 rtl/fixed_divider.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/fixed_divider.sv
// fixed_divider: iterative signed Q16.16 divider (radix-2 restoring, one quotient bit per cycle).
// Optional macro DIVIDER_ROUND_EN adds a guard iteration and rounds the magnitude half-up.
module fixed_divider #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] num,
    input  logic [WIDTH-1:0] den,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             busy,
    output logic             div_by_zero,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    localparam int DW = WIDTH + FRAC;
`ifdef DIVIDER_ROUND_EN
    localparam int ITER = DW + 1;
`else
    localparam int ITER = DW;
`endif
    localparam int CW = $clog2(ITER + 1);
    localparam int RW = ITER + 1;

    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Handshake: start is a pulse honoured only in IDLE (no queueing); valid is an
    // unconditional two-cycle strobe with no backpressure, flags qualify it.
    state_t           state_q, state_d;
    logic             sign_q, sign_d;
    logic             num_neg_q, num_neg_d;
    logic             dz_pend_q, dz_pend_d;
    logic [DW-1:0]    dividend_q, dividend_d;
    logic [WIDTH:0]   den_mag_q, den_mag_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [ITER-1:0]  quot_q, quot_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             div_by_zero_q, div_by_zero_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH-1:0] num_mag;
    logic [WIDTH-1:0] den_abs;
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [RW-1:0]    q_rnd;
    logic [RW-1:0]    lim_pos;
    logic [RW-1:0]    lim_neg;
    logic [WIDTH-1:0] res_mag;

    // Magnitude of the most-negative operand is 2^(WIDTH-1), exact as an unsigned value.
    assign num_mag = num[WIDTH-1] ? (~num + 1'b1) : num;
    assign den_abs = den[WIDTH-1] ? (~den + 1'b1) : den;

    assign rem_shift = {rem_q, dividend_q[DW-1]};
    assign rem_ge    = (rem_shift >= den_mag_q);

`ifdef DIVIDER_ROUND_EN
    assign q_rnd = ({1'b0, quot_q} + RW'(1)) >> 1;
`else
    assign q_rnd = {1'b0, quot_q};
`endif

    assign lim_pos = RW'(POS_MAX);
    assign lim_neg = RW'(NEG_MIN);
    assign res_mag = q_rnd[WIDTH-1:0];

    always_comb begin
        state_d       = state_q;
        sign_d        = sign_q;
        num_neg_d     = num_neg_q;
        dz_pend_d     = dz_pend_q;
        dividend_d    = dividend_q;
        den_mag_d     = den_mag_q;
        rem_d         = rem_q;
        quot_d        = quot_q;
        count_d       = count_q;
        out_d         = out_q;
        valid_d       = valid_q;
        busy_d        = busy_q;
        div_by_zero_d = div_by_zero_q;
        overflow_d    = overflow_q;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    sign_d        = num[WIDTH-1] ^ den[WIDTH-1];
                    num_neg_d     = num[WIDTH-1];
                    dividend_d    = {num_mag, {FRAC{1'b0}}};
                    den_mag_d     = {1'b0, den_abs};
                    rem_d         = '0;
                    quot_d        = '0;
                    count_d       = CW'(ITER);
                    div_by_zero_d = 1'b0;
                    overflow_d    = 1'b0;
                    busy_d        = 1'b1;
                    if (den == '0) begin
                        dz_pend_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        dz_pend_d = 1'b0;
                        state_d   = DIVIDE;
                    end
                end
            end

            DIVIDE: begin
                // Remainder stays below |den| <= 2^(WIDTH-1), so WIDTH bits hold it.
                dividend_d = {dividend_q[DW-2:0], 1'b0};
                rem_d      = rem_ge ? WIDTH'(rem_shift - den_mag_q) : WIDTH'(rem_shift);
                quot_d     = {quot_q[ITER-2:0], rem_ge};
                count_d    = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                valid_d = 1'b1;
                state_d = HOLD;
                if (dz_pend_q) begin
                    out_d         = num_neg_q ? NEG_MIN : POS_MAX;
                    div_by_zero_d = 1'b1;
                    overflow_d    = 1'b0;
                end else if (sign_q) begin
                    if (q_rnd > lim_neg) begin
                        out_d      = NEG_MIN;
                        overflow_d = 1'b1;
                    end else begin
                        out_d = -res_mag;
                    end
                end else begin
                    if (q_rnd > lim_pos) begin
                        out_d      = POS_MAX;
                        overflow_d = 1'b1;
                    end else begin
                        out_d = res_mag;
                    end
                end
            end

            HOLD: begin
                valid_d = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            sign_q        <= 1'b0;
            num_neg_q     <= 1'b0;
            dz_pend_q     <= 1'b0;
            dividend_q    <= '0;
            den_mag_q     <= '0;
            rem_q         <= '0;
            quot_q        <= '0;
            count_q       <= '0;
            out_q         <= '0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sign_q        <= sign_d;
            num_neg_q     <= num_neg_d;
            dz_pend_q     <= dz_pend_d;
            dividend_q    <= dividend_d;
            den_mag_q     <= den_mag_d;
            rem_q         <= rem_d;
            quot_q        <= quot_d;
            count_q       <= count_d;
            out_q         <= out_d;
            valid_q       <= valid_d;
            busy_q        <= busy_d;
            div_by_zero_q <= div_by_zero_d;
            overflow_q    <= overflow_d;
        end
    end

    assign out         = out_q;
    assign valid       = valid_q;
    assign busy        = busy_q;
    assign div_by_zero = div_by_zero_q;
    assign overflow    = overflow_q;
    assign dbg_state   = state_q;

endmodule
